// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter state encoding.
package uart_pkg;

    // 50 MHz / 115200 baud; the receiver uses the same value so the two can loop back.
    localparam int UART_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count; a push while full or a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap without explicit compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop serialiser, LSB first.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tx_valid,
    input  logic [7:0]     tx_data,
    output logic           tx_ready,
    output logic           output_serial,
    output logic           busy,
    output uart_tx_state_e tx_state
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_tx_state_e state;
    logic [BW-1:0]  baud;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           baud_last;

    logic           fifo_pop;
    logic [7:0]     fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [AW:0]    fifo_count;

    // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
    // the producer holds tx_valid/tx_data stable until that edge.
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign baud_last = (baud == BAUD_LAST);
    // Pop from IDLE, or on the last stop-bit cycle so frames run back to back.
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || (state == STOP && baud_last));
    assign tx_ready  = !fifo_full;
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign tx_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            baud          <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            output_serial <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    output_serial <= 1'b1;
                    if (fifo_pop) begin
                        shift         <= fifo_head;
                        baud          <= '0;
                        bit_idx       <= '0;
                        output_serial <= 1'b0;
                        state         <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud          <= '0;
                        bit_idx       <= '0;
                        output_serial <= shift[0];
                        state         <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            output_serial <= 1'b1;
                            state         <= STOP;
                        end else begin
                            shift         <= shift >> 1;
                            output_serial <= shift[1];
                            bit_idx       <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (fifo_pop) begin
                            shift         <= fifo_head;
                            bit_idx       <= '0;
                            output_serial <= 1'b0;
                            state         <= START;
                        end else begin
                            output_serial <= 1'b1;
                            state         <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    output_serial <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;      // bit k = line level during bit slot k (0 = start, 9 = stop)
    int         busy_cycles;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tx_valid = 1'b0;
  logic [7:0]     tx_data = 8'h00;
  logic           tx_ready;
  logic           output_serial;
  logic           busy;
  uart_tx_state_e tx_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  logic       cap_line [0:127];
  logic       cap_busy [0:127];
  vec_t       vecs [5];

  uart_transmitter #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .output_serial (output_serial),
    .busy          (busy),
    .tx_state      (tx_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Caller is a couple of ns after a posedge; one rising edge sees rst high.
  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // driver: called at a negedge, returns at the negedge after the accepting edge
  task automatic push_byte(input logic [7:0] d, output int acc);
    int waited;
    waited   = 0;
    acc      = -1;
    tx_valid = 1'b1;
    tx_data  = d;
    while (waited < 200) begin
      if (tx_ready) begin
        @(posedge clk);
        acc = cyc;
        exp_q.push_back(d);
        @(negedge clk);
        return;
      end
      @(negedge clk);
      waited++;
    end
    chk("push_timeout", {31'd0, tx_ready}, 32'd1);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_line[i] = output_serial;
      cap_busy[i] = busy;
      @(negedge clk);
    end
  endtask

  task automatic check_slots(input string tag, input int base, input logic [9:0] frame);
    logic [3:0] act;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) act[j] = cap_line[base + k*CPB + j];
      chk($sformatf("%s_slot%0d", tag, k), {28'd0, act}, {28'd0, {4{frame[k]}}});
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // scoreboard: decode frames off the line and compare against exp_q
  int         mon_cnt    = 0;
  logic       mon_active = 1'b0;
  logic [7:0] mon_byte   = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (output_serial == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      for (int i = 0; i < 8; i++)
        if (mon_cnt == (1 + i)*CPB + CPB/2) mon_byte[i] = output_serial;
      if (mon_cnt == 9*CPB + CPB/2) begin
        chk("stop_bit", {31'd0, output_serial}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: got 0x%02h expected no frame", mon_byte);
        end else begin
          chk("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    int acc;
    int accs [6];
    int exp_acc [6];
    logic ok;

    vecs[0] = '{data: 8'hA5, frame: 10'b1_10100101_0, busy_cycles: 41};
    vecs[1] = '{data: 8'h00, frame: 10'b1_00000000_0, busy_cycles: 41};
    vecs[2] = '{data: 8'hFF, frame: 10'b1_11111111_0, busy_cycles: 41};
    vecs[3] = '{data: 8'h3C, frame: 10'b1_00111100_0, busy_cycles: 41};
    vecs[4] = '{data: 8'h81, frame: 10'b1_10000001_0, busy_cycles: 41};
    exp_acc = '{0, 1, 2, 3, 4, 42};

    // reset state, sampled while rst is still asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_serial", {31'd0, output_serial}, 32'd1);
    chk("reset_busy",   {31'd0, busy},          32'd0);
    chk("reset_ready",  {31'd0, tx_ready},      32'd1);
    chk("reset_state",  32'(tx_state),          32'(IDLE));
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // idle hold
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ok = ok && output_serial && !busy;
      @(negedge clk);
    end
    chk("idle_hold", {31'd0, ok}, 32'd1);

    // single-byte frames from the table
    for (int v = 0; v < 5; v++) begin
      push_byte(vecs[v].data, acc);
      tx_valid = 1'b0;
      capture(50);
      chk($sformatf("v%0d_line_before_pop", v), {31'd0, cap_line[0]}, 32'd1);
      check_slots($sformatf("v%0d", v), 1, vecs[v].frame);
      chk($sformatf("v%0d_line_after_stop", v), {31'd0, cap_line[41]}, 32'd1);
      begin
        int nb;
        nb = 0;
        for (int i = 0; i < 50; i++) nb += int'(cap_busy[i]);
        chk($sformatf("v%0d_busy_cycles", v), nb, vecs[v].busy_cycles);
      end
      wait_idle();
    end

    // back-to-back: 0x00 then 0xFF on consecutive cycles
    push_byte(8'h00, acc);
    push_byte(8'hFF, acc);
    tx_valid = 1'b0;
    capture(82);
    check_slots("b2b0", 0,  vecs[1].frame);
    check_slots("b2b1", 40, vecs[2].frame);
    chk("b2b_busy_last_stop", {31'd0, cap_busy[79]}, 32'd1);
    chk("b2b_busy_after",     {31'd0, cap_busy[80]}, 32'd0);
    chk("b2b_line_after",     {31'd0, cap_line[80]}, 32'd1);
    wait_idle();

    // full FIFO with tx_valid held
    for (int k = 0; k < 6; k++) begin
      push_byte(8'h11 * (k + 1), accs[k]);
      if (k == 4) chk("ready_low_when_full", {31'd0, tx_ready}, 32'd0);
    end
    tx_valid = 1'b0;
    for (int k = 0; k < 6; k++)
      chk($sformatf("full_accept%0d", k), accs[k] - accs[0], exp_acc[k]);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    // reset in data bit 3 with a second byte still queued
    push_byte(8'h3C, acc);
    push_byte(8'h99, acc);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("rst1_bit3_level", {31'd0, output_serial}, 32'd1);
    chk("rst1_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2;
    reset_pulse();
    exp_q.delete();
    chk("rst1_serial", {31'd0, output_serial}, 32'd1);
    chk("rst1_busy",   {31'd0, busy},          32'd0);
    chk("rst1_ready",  {31'd0, tx_ready},      32'd1);
    chk("rst1_state",  32'(tx_state),          32'(IDLE));
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ok = ok && output_serial && !busy && tx_ready;
      @(negedge clk);
    end
    chk("rst1_no_more_frames", {31'd0, ok}, 32'd1);

    // reset during the start bit: the line must return high
    push_byte(8'h5A, acc);
    tx_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rst2_start_bit", {31'd0, output_serial}, 32'd0);
    reset_pulse();
    exp_q.delete();
    chk("rst2_serial", {31'd0, output_serial}, 32'd1);
    chk("rst2_busy",   {31'd0, busy},          32'd0);
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ok = ok && output_serial && !busy;
      @(negedge clk);
    end
    chk("rst2_no_more_frames", {31'd0, ok}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
